// File: rtl/alu_pkg.sv
// Shared ALU definitions: command encodings, NZCV bit positions and the
// rule for which commands are allowed to write the C and V flags.
package alu_pkg;

  localparam logic [3:0] AND = 4'b0000;
  localparam logic [3:0] EOR = 4'b0001;
  localparam logic [3:0] SUB = 4'b0010;
  localparam logic [3:0] RSB = 4'b0011;
  localparam logic [3:0] ADD = 4'b0100;
  localparam logic [3:0] ADC = 4'b0101;
  localparam logic [3:0] SBC = 4'b0110;
  localparam logic [3:0] CMP = 4'b0111;
  localparam logic [3:0] ORR = 4'b1100;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Commands whose carry/overflow outputs are architecturally meaningful.
  function automatic logic cv_write(input logic [3:0] cmd);
    logic hit;
    case (cmd)
      AND, EOR, SUB, RSB, CMP: hit = 1'b1;
      default:                 hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker: first set request at or after
// ptr (wrapping), returned both one-hot and as an index.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  // Scan from the farthest offset down so the nearest hit to ptr wins.
  always_comb begin
    logic [IW-1:0] idx;
    gnt_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx     = IW'((int'(ptr) + k) % N);
      gnt_idx = req[idx] ? idx : gnt_idx;
    end
    gnt = (|req) ? (N'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Shares one combinational ALU between N_REQ requesters: round-robin issue,
// two-stage pipeline and one NZCV register per requester.
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ-1:0]            req_alu_op,
  input  logic [N_REQ-1:0]            req_s,
  input  logic [N_REQ-1:0][3:0]       req_cmd,
  input  logic [N_REQ-1:0][WIDTH-1:0] req_a,
  input  logic [N_REQ-1:0][WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]            alu_a,
  output logic [WIDTH-1:0]            alu_b,
  output logic [3:0]                  alu_control,
  input  logic [WIDTH-1:0]            alu_result,
  input  logic [3:0]                  alu_nzcv,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [WIDTH-1:0]            rsp_result,
  output logic [N_REQ-1:0][3:0]       rsp_flags
);

  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0]    ptr_r;
  logic [N_REQ-1:0] gnt_s;
  logic [IW-1:0]    gnt_idx_s;
  logic             hs_s;

  logic             v1_r;
  logic             s1_op_r;
  logic             s1_s_r;
  logic [3:0]       s1_cmd_r;
  logic [IW-1:0]    s1_own_r;

  logic             nz_we_s;
  logic             cv_we_s;
  logic [3:0]       flag_cur_s;
  logic [3:0]       flag_next_s;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req     (req_valid),
    .ptr     (ptr_r),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  assign req_ready = gnt_s;
  assign hs_s      = |gnt_s;

  // Pointer advance and issue stage: capture the granted request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_r       <= '0;
      v1_r        <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= 4'b0000;
      s1_op_r     <= 1'b0;
      s1_s_r      <= 1'b0;
      s1_cmd_r    <= 4'b0000;
      s1_own_r    <= '0;
    end else begin
      v1_r <= hs_s;
      if (hs_s) begin
        ptr_r       <= (gnt_idx_s == IW'(N_REQ - 1)) ? '0 : gnt_idx_s + IW'(1);
        alu_a       <= req_a[gnt_idx_s];
        alu_b       <= req_b[gnt_idx_s];
        alu_control <= req_alu_op[gnt_idx_s] ? req_cmd[gnt_idx_s] : ADD;
        s1_op_r     <= req_alu_op[gnt_idx_s];
        s1_s_r      <= req_s[gnt_idx_s];
        s1_cmd_r    <= req_cmd[gnt_idx_s];
        s1_own_r    <= gnt_idx_s;
      end
    end
  end

  // Address adds (alu_op=0) never touch flags, even with s set.
  always_comb begin
    nz_we_s     = s1_s_r & s1_op_r;
    cv_we_s     = nz_we_s & cv_write(s1_cmd_r);
    flag_cur_s  = rsp_flags[s1_own_r];
    flag_next_s = {nz_we_s ? alu_nzcv[3:2] : flag_cur_s[3:2],
                   cv_we_s ? alu_nzcv[1:0] : flag_cur_s[1:0]};
  end

  // Response stage: return the result and commit the owner's flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else begin
      rsp_valid <= v1_r ? (N_REQ'(1) << s1_own_r) : '0;
      if (v1_r) begin
        rsp_result          <= alu_result;
        rsp_flags[s1_own_r] <= flag_next_s;
      end
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with a small combinational ALU model whose
// flag output is steered by the stimulus.
module tb_alu_rr_arbiter;
  import alu_pkg::*;

  localparam int N = 4;
  localparam int W = 32;

  logic                clk = 1'b0;
  logic                reset;
  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic [N-1:0]        req_alu_op;
  logic [N-1:0]        req_s;
  logic [N-1:0][3:0]   req_cmd;
  logic [N-1:0][W-1:0] req_a;
  logic [N-1:0][W-1:0] req_b;
  logic [W-1:0]        alu_a;
  logic [W-1:0]        alu_b;
  logic [3:0]          alu_control;
  logic [W-1:0]        alu_result;
  logic [3:0]          alu_nzcv;
  logic [N-1:0]        rsp_valid;
  logic [W-1:0]        rsp_result;
  logic [N-1:0][3:0]   rsp_flags;

  logic [3:0] nzcv_drv;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_rr_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_alu_op  (req_alu_op),
    .req_s       (req_s),
    .req_cmd     (req_cmd),
    .req_a       (req_a),
    .req_b       (req_b),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .alu_nzcv    (alu_nzcv),
    .rsp_valid   (rsp_valid),
    .rsp_result  (rsp_result),
    .rsp_flags   (rsp_flags)
  );

  always_comb begin
    case (alu_control)
      ADD:     alu_result = alu_a + alu_b;
      SUB:     alu_result = alu_a - alu_b;
      AND:     alu_result = alu_a & alu_b;
      default: alu_result = alu_a | alu_b;
    endcase
  end
  assign alu_nzcv = nzcv_drv;

  // A waiting (valid, not granted) requester must keep its inputs unchanged.
  logic [N-1:0] pend_q   = '0;
  logic         hold_err = 1'b0;
  logic [69:0]  snap_q [N];
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (pend_q[i] && req_valid[i] &&
          (snap_q[i] !== {req_alu_op[i], req_s[i], req_cmd[i], req_a[i], req_b[i]}))
        hold_err <= 1'b1;
      pend_q[i] <= req_valid[i] & ~req_ready[i];
      snap_q[i] <= {req_alu_op[i], req_s[i], req_cmd[i], req_a[i], req_b[i]};
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic op, input logic s, input logic [3:0] cmd,
                         input logic [31:0] a, input logic [31:0] b);
    req_alu_op[i] = op;
    req_s[i]      = s;
    req_cmd[i]    = cmd;
    req_a[i]      = a;
    req_b[i]      = b;
  endtask

  logic [3:0]  rot_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [31:0] rot_res [5] = '{32'h10, 32'h21, 32'h32, 32'h43, 32'h10};

  initial begin
    reset      = 1'b0;
    req_valid  = '0;
    req_alu_op = '0;
    req_s      = '0;
    req_cmd    = '0;
    req_a      = '0;
    req_b      = '0;
    nzcv_drv   = 4'b0000;

    cyc(); cyc(); cyc();
    chk("rst_ready",   64'(req_ready),   64'(4'b0000));
    chk("rst_rsp",     64'(rsp_valid),   64'(4'b0000));
    chk("rst_result",  64'(rsp_result),  64'(32'h0));
    chk("rst_alu_a",   64'(alu_a),       64'(32'h0));
    chk("rst_alu_b",   64'(alu_b),       64'(32'h0));
    chk("rst_control", 64'(alu_control), 64'(4'b0000));
    chk("rst_flags",   64'(rsp_flags),   64'(16'h0000));
    reset = 1'b1;

    // Rotation with all four requesters active.
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, ADD, 32'(32'h10 * (i + 1)), 32'(i));
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rot_gnt%0d", k), 64'(req_ready), 64'(rot_gnt[k]));
      if (k >= 2) begin
        chk($sformatf("rot_rsp%0d", k), 64'(rsp_valid), 64'(rot_gnt[k-2]));
        chk($sformatf("rot_res%0d", k), 64'(rsp_result), 64'(rot_res[k-2]));
      end else begin
        chk($sformatf("rot_rsp%0d", k), 64'(rsp_valid), 64'(4'b0000));
      end
      if (k == 4) req_valid = 4'b0001;
      cyc();
    end
    chk("rot_rsp5", 64'(rsp_valid),  64'(4'b1000));
    chk("rot_res5", 64'(rsp_result), 64'(32'h43));
    req_valid = 4'b0000;
    cyc();
    chk("rot_rsp6",   64'(rsp_valid),  64'(4'b0001));
    chk("rot_res6",   64'(rsp_result), 64'(32'h10));
    chk("rot_flags",  64'(rsp_flags),  64'(16'h0000));

    // SUB with flags from requester 2.
    set_req(2, 1'b1, 1'b1, SUB, 32'd5, 32'd5);
    nzcv_drv  = 4'b0110;
    req_valid = 4'b0100;
    #1;
    chk("sub_gnt", 64'(req_ready), 64'(4'b0100));
    cyc();
    req_valid = 4'b0000;
    chk("sub_ctrl", 64'(alu_control), 64'(4'b0010));
    chk("sub_a",    64'(alu_a),       64'(32'd5));
    cyc();
    chk("sub_rsp",   64'(rsp_valid),  64'(4'b0100));
    chk("sub_res",   64'(rsp_result), 64'(32'h0));
    chk("sub_flags", 64'(rsp_flags),  64'(16'h0600));

    // Back-to-back ops from requester 1: AND then ORR.
    set_req(1, 1'b1, 1'b1, AND, 32'hF0, 32'h0F);
    nzcv_drv  = 4'b1011;
    req_valid = 4'b0010;
    #1;
    chk("and_gnt", 64'(req_ready), 64'(4'b0010));
    cyc();
    set_req(1, 1'b1, 1'b1, 4'b1100, 32'hF0, 32'h0F);
    #1;
    chk("orr_gnt",  64'(req_ready),   64'(4'b0010));
    chk("and_ctrl", 64'(alu_control), 64'(4'b0000));
    cyc();
    nzcv_drv  = 4'b0100;
    req_valid = 4'b0000;
    chk("and_rsp",   64'(rsp_valid),    64'(4'b0010));
    chk("and_res",   64'(rsp_result),   64'(32'h0));
    chk("and_flags", 64'(rsp_flags[1]), 64'(4'b1011));
    cyc();
    chk("orr_rsp",   64'(rsp_valid),  64'(4'b0010));
    chk("orr_res",   64'(rsp_result), 64'(32'hFF));
    chk("orr_flags", 64'(rsp_flags),  64'(16'h0670));

    // Address add ignores cmd and s.
    set_req(0, 1'b0, 1'b1, 4'b1111, 32'h100, 32'h4);
    nzcv_drv  = 4'b1111;
    req_valid = 4'b0001;
    #1;
    chk("adr_gnt", 64'(req_ready), 64'(4'b0001));
    cyc();
    req_valid = 4'b0000;
    chk("adr_ctrl", 64'(alu_control), 64'(4'b0100));
    cyc();
    chk("adr_rsp",   64'(rsp_valid),  64'(4'b0001));
    chk("adr_res",   64'(rsp_result), 64'(32'h104));
    chk("adr_flags", 64'(rsp_flags),  64'(16'h0670));

    // Pointer wrap 3->0, then requester 3 waits behind 0 and 1.
    set_req(0, 1'b1, 1'b0, ADD, 32'd1, 32'd1);
    set_req(1, 1'b1, 1'b0, ADD, 32'd2, 32'd2);
    set_req(3, 1'b1, 1'b0, ADD, 32'd3, 32'd3);
    req_valid = 4'b1000;
    #1;
    chk("wrap_gnt3", 64'(req_ready), 64'(4'b1000));
    cyc();
    req_valid = 4'b1011;
    #1;
    chk("wrap_gnt0", 64'(req_ready), 64'(4'b0001));
    cyc();
    chk("hold_gnt1", 64'(req_ready),  64'(4'b0010));
    chk("hold_rsp3", 64'(rsp_valid),  64'(4'b1000));
    chk("hold_res3", 64'(rsp_result), 64'(32'd6));
    cyc();
    chk("hold_gnt3", 64'(req_ready),  64'(4'b1000));
    chk("hold_rsp0", 64'(rsp_valid),  64'(4'b0001));
    chk("hold_res0", 64'(rsp_result), 64'(32'd2));
    cyc();
    chk("hold_gnt0b", 64'(req_ready),  64'(4'b0001));
    chk("hold_rsp1",  64'(rsp_valid),  64'(4'b0010));
    chk("hold_res1",  64'(rsp_result), 64'(32'd4));
    req_valid = 4'b0000;
    cyc();
    chk("hold_rsp3b", 64'(rsp_valid),  64'(4'b1000));
    chk("hold_res3b", 64'(rsp_result), 64'(32'd6));
    cyc();
    chk("hold_idle",  64'(rsp_valid), 64'(4'b0000));
    chk("hold_flags", 64'(rsp_flags), 64'(16'h0670));

    // Reset in the cycle after a handshake drops the operation.
    set_req(2, 1'b1, 1'b1, SUB, 32'd9, 32'd9);
    nzcv_drv  = 4'b1111;
    req_valid = 4'b0100;
    #1;
    chk("mid_gnt", 64'(req_ready), 64'(4'b0100));
    cyc();
    req_valid = 4'b0000;
    reset     = 1'b0;
    #1;
    chk("mid_rsp",   64'(rsp_valid),   64'(4'b0000));
    chk("mid_flags", 64'(rsp_flags),   64'(16'h0000));
    chk("mid_alu_a", 64'(alu_a),       64'(32'h0));
    chk("mid_ctrl",  64'(alu_control), 64'(4'b0000));
    chk("mid_res",   64'(rsp_result),  64'(32'h0));
    cyc();
    chk("mid_rsp2", 64'(rsp_valid), 64'(4'b0000));
    reset = 1'b1;
    cyc();
    chk("mid_rsp3", 64'(rsp_valid), 64'(4'b0000));
    set_req(1, 1'b1, 1'b0, ADD, 32'd7, 32'd8);
    req_valid = 4'b0010;
    #1;
    chk("post_gnt", 64'(req_ready), 64'(4'b0010));
    cyc();
    req_valid = 4'b0000;
    cyc();
    chk("post_rsp",   64'(rsp_valid),  64'(4'b0010));
    chk("post_res",   64'(rsp_result), 64'(32'd15));
    chk("post_flags", 64'(rsp_flags),  64'(16'h0000));

    chk("req_hold", 64'(hold_err), 64'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_rr_arbiter.md
# alu_rr_arbiter

Round-robin arbiter that shares the single ALU datapath between `N_REQ` requesters (processing elements of the multicore/vector datapath). Requests are accepted with a valid/ready handshake. Each request's operands and 4-bit ALU command are registered and driven to the shared ALU. The result and condition flags are captured and returned to the owning requester. The block also keeps one architectural NZCV flag register per requester and applies the standard flag-write rules.

## Interface

**Parameters**
- `N_REQ`, 4: number of requesters (2–8).
- `WIDTH`, 32: operand and result width.

**Ports**
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, `N_REQ`: request pending per requester.
- `req_ready`, out, `N_REQ`: one-hot grant. A handshake completes in any cycle where `req_valid[i] & req_ready[i]`.
- `req_alu_op`, in, `N_REQ`: 1 = data-processing op; 0 = address add (no flag effects).
- `req_s`, in, `N_REQ`: set-flags bit.
- `req_cmd`, in, `N_REQ`×4: ALU command.
- `req_a`, `req_b`, in, `N_REQ`×`WIDTH`: operands.
- `alu_a`, `alu_b`, out, `WIDTH`: registered operands to the shared ALU.
- `alu_control`, out, 4: `req_cmd` when `alu_op` = 1; `ADD` (4'b0100) when `alu_op` = 0.
- `alu_result`, in, `WIDTH`: combinational ALU result.
- `alu_nzcv`, in, 4: combinational ALU flags.
- `rsp_valid`, out, `N_REQ`: one-hot, one-cycle response pulse.
- `rsp_result`, out, `WIDTH`: registered result, valid while any `rsp_valid` bit is high.
- `rsp_flags`, out, `N_REQ`×4: per-requester architectural NZCV registers.

## Operation

- **Arbitration:** round-robin pointer `ptr`. Grant the first requester with `req_valid` set, scanning `ptr, ptr+1, … mod N_REQ`. After a handshake, `ptr` = granted index + 1, wrapping. With no request, `ptr` holds.
- **Grant logic:** `req_ready` is combinational from `req_valid` and `ptr`. At most one bit is set. The pipeline never stalls, so some grant is issued whenever any `req_valid` is high.
- **Requester rule:** hold `req_*` stable while `req_valid` is high and not granted. The bench asserts on any violation.
- **Stage 1 (issue):** on handshake, register `a`, `b`, `cmd`, `alu_op`, `s` and the owner index, and set `v1`=1. Otherwise `v1`=0. When `v1`=0, `alu_a`/`alu_b`/`alu_control` hold their last values.
- **Stage 2 (response):** when `v1`=1:
  - register `alu_result` into `rsp_result`;
  - set `v2`=1 and pulse `rsp_valid[owner]`;
  - update the owner's flags as below.
- **Flag write (applied to the owner's register only):**
  - N,Z ← `alu_nzcv[3:2]` when `s`=1.
  - C,V ← `alu_nzcv[1:0]` when `s`=1 AND `alu_op`=1 AND `cmd` ∈ {0000, 0001, 0010, 0011, 0111}.
  - With `alu_op`=0, no flags change regardless of `s`.
- **Visibility:** the new flag value is visible on `rsp_flags` in the same cycle as `rsp_valid`.
- **No backpressure on responses:** the requester must sample in the `rsp_valid` cycle.
- **Reset (asynchronous, active-low):** on `reset` low, set `ptr`=0, `v1`=`v2`=0, `rsp_valid`=0, `rsp_result`=0, `alu_a`=`alu_b`=0, `alu_control`=0, and all `rsp_flags`=0. In-flight operations are dropped with no response. After release, the first grant follows the scan from index 0.

## Timing

- **Latency:** handshake at edge E0, then `rsp_valid` high during the cycle after E1 (2 clocks).
- **Throughput:** one operation per cycle. Back-to-back grants to different requesters produce back-to-back responses in grant order.
- **Single active requester:** it may be granted every cycle.
- **Flag hazard:** two consecutive flag-setting ops from the same requester are applied in order. The second op sees the first op's flags on `rsp_flags` one cycle before its own response.
- **Combinational ALU:** the ALU is combinational between `alu_*` outputs and `alu_result`/`alu_nzcv` within one cycle. The block adds no path from `req_*` to `alu_*`.

## Structure

- **Shared package `alu_pkg`:**
  - 4-bit command constants: `AND`=0000, `EOR`=0001, `SUB`=0010, `RSB`=0011, `ADD`=0100, `CMP`=0111, etc.
  - NZCV bit index constants.
  - `function cv_write(cmd)` returning the C/V-update set.
- **Sub-module `rr_pick`:** parameterized round-robin priority picker, (`req[N]`, `ptr`) → (one-hot `gnt`, `gnt_idx`). It is combinational and reusable by other arbiters.

## Test plan

1. **Rotation:** reset, then all four `req_valid` held high with distinct ops.
   - Grants go to 0,1,2,3,0 on consecutive cycles.
   - `rsp_valid` is one-hot in the same order, 2 cycles later.
2. **SUB flags:** requester 2 sends `cmd`=0010, `s`=1, `alu_op`=1, `a`=5, `b`=5 with the ALU model returning NZCV=0110.
   - `rsp_result`=0.
   - `rsp_flags[2]`=0110; other requesters' flags are unchanged.
3. **Logical op:** requester 1 sends `cmd`=0000 (AND), `s`=1, with ALU NZCV=1011 and prior flags 0000.
   - New flags are 1011, since 0000 is in the C/V set.
   - Then `cmd`=1100, `s`=1, ALU NZCV=0100 gives flags 0111: only NZ updated.
4. **Address add:** `alu_op`=0, `s`=1, `cmd`=1111, `a`=0x100, `b`=0x4.
   - `alu_control`=0100.
   - `rsp_result`=0x104.
   - Flags unchanged.
5. **Hold and wrap:** requester 3 waits while `ptr`=0 and requesters 0 and 1 are active.
   - Requester 3's inputs stay stable and it is granted within `N_REQ` cycles.
   - The pointer wraps 3→0.
6. **Reset mid-operation:** assert `reset` low in the cycle after a handshake.
   - No `rsp_valid` appears.
   - All flags read 0.
   - After release, a single request from requester 1 is granted immediately.
